// File: rtl/grey_pkg.sv
// Shared definitions for the Gray/binary tracking blocks: widths, FSM state
// encoding and the Gray-to-binary conversion used by RTL and benches.
package grey_pkg;

   localparam int unsigned WIDTH_DEFAULT = 4;
   localparam int unsigned POS_W         = 8;
   localparam int unsigned ERR_W         = 4;
   localparam logic [ERR_W-1:0] ERR_MAX  = 4'hF;

   typedef logic [0:0] state_t;
   localparam state_t INIT  = 1'b0;
   localparam state_t TRACK = 1'b1;

   // Zero-extended Gray words convert correctly at any width up to 32.
   function automatic logic [31:0] gray2bin(input logic [31:0] gw);
      logic [31:0] r;
      r[31] = gw[31];
      for (int i = 30; i >= 0; i--) begin
         r[i] = r[i+1] ^ gw[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/grey_sync2.sv
// Two-flop synchronizer for a Gray-coded word from another clock domain.
module grey_sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/grey_to_bin_tracker.sv
// Tracks a synchronized Gray counter: binary value, step direction, a wrapping
// position accumulator and a saturating count of illegal multi-bit steps.
module grey_to_bin_tracker
   import grey_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] g,
   input  logic             clear,
   output logic [WIDTH-1:0] b,
   output logic             valid,
   output logic             dir,
   output logic             step_err,
   output logic [7:0]       pos,
   output logic [3:0]       err_cnt
);

   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] gprev;
   logic [WIDTH-1:0] new_b;
   logic [WIDTH-1:0] diff;
   logic             single_step;
   logic             up_step;

   state_t           state, state_n;
   logic [1:0]       init_cnt, init_cnt_n;
   logic [WIDTH-1:0] b_n;
   logic             valid_n, dir_n, step_err_n;
   logic [POS_W-1:0] pos_n;
   logic [ERR_W-1:0] err_cnt_n;

   grey_sync2 #(.WIDTH(WIDTH)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (g),
      .q   (s2)
   );

   assign new_b       = WIDTH'(gray2bin(32'(s2)));
   assign diff        = s2 ^ gprev;
   assign single_step = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
   assign up_step     = (new_b == WIDTH'(b + WIDTH'(1)));

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         init_cnt <= 2'd0;
         gprev    <= '0;
         b        <= '0;
         valid    <= 1'b0;
         dir      <= 1'b0;
         step_err <= 1'b0;
         pos      <= '0;
         err_cnt  <= '0;
      end else begin
         state    <= state_n;
         init_cnt <= init_cnt_n;
         gprev    <= s2;
         b        <= b_n;
         valid    <= valid_n;
         dir      <= dir_n;
         step_err <= step_err_n;
         pos      <= pos_n;
         err_cnt  <= err_cnt_n;
      end
   end

   // Next state and next outputs
   always_comb begin
      state_n    = state;
      init_cnt_n = init_cnt;
      b_n        = b;
      valid_n    = 1'b0;
      dir_n      = dir;
      step_err_n = 1'b0;
      pos_n      = pos;
      err_cnt_n  = err_cnt;

      case (state)
         INIT: begin
            // Two edges fill the synchronizer; the third loads b from s2.
            if (init_cnt == 2'd2) begin
               b_n        = new_b;
               init_cnt_n = 2'd0;
               state_n    = TRACK;
            end else begin
               init_cnt_n = init_cnt + 2'd1;
            end
         end
         TRACK: begin
            if (diff != '0) begin
               b_n     = new_b;
               valid_n = 1'b1;
               if (single_step) begin
                  dir_n = up_step;
                  pos_n = up_step ? pos + 8'd1 : pos - 8'd1;
               end else begin
                  step_err_n = 1'b1;
                  if (err_cnt != ERR_MAX) begin
                     err_cnt_n = err_cnt + 4'd1;
                  end
               end
            end
         end
         default: begin
            state_n    = INIT;
            init_cnt_n = 2'd0;
         end
      endcase

      if (clear) begin
         pos_n     = '0;
         err_cnt_n = '0;
      end
   end

endmodule

// File: tb/tb_grey_to_bin_tracker.sv
// Directed bench for grey_to_bin_tracker: reset, full Gray walk, wraps,
// illegal jumps with saturation, clear/step collision and mid-flight reset.
module tb_grey_to_bin_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] g;
   logic       clear;
   logic [3:0] b;
   logic       valid;
   logic       dir;
   logic       step_err;
   logic [7:0] pos;
   logic [3:0] err_cnt;

   int n_vec = 0;
   int n_bad = 0;
   int n_valid = 0;
   int n_serr = 0;
   int snap_v, snap_e;

   // Up Gray sequence for binary 1..15 then 0
   logic [3:0] gray_up [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

   grey_to_bin_tracker #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .g        (g),
      .clear    (clear),
      .b        (b),
      .valid    (valid),
      .dir      (dir),
      .step_err (step_err),
      .pos      (pos),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (valid)    n_valid++;
      if (step_err) n_serr++;
   end

   task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply a new Gray word and check the result two edges after capture.
   task automatic apply_step(input string tag, input logic [3:0] gv, input logic [3:0] exp_b,
                             input logic exp_dir, input logic exp_serr);
      g = gv;
      tick();
      tick();
      chk_vec({tag, "_early_valid"}, 32'(valid), 32'd0);
      tick();
      chk_vec({tag, "_valid"}, 32'(valid), 32'd1);
      chk_vec({tag, "_b"}, 32'(b), 32'(exp_b));
      chk_vec({tag, "_dir"}, 32'(dir), 32'(exp_dir));
      chk_vec({tag, "_serr"}, 32'(step_err), 32'(exp_serr));
      tick();
      chk_vec({tag, "_valid_drop"}, 32'(valid), 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      g     = 4'b0000;
      clear = 1'b0;
      tick();
      tick();

      // Reset state
      chk_vec("rst_b", 32'(b), 32'd0);
      chk_vec("rst_valid", 32'(valid), 32'd0);
      chk_vec("rst_serr", 32'(step_err), 32'd0);
      chk_vec("rst_dir", 32'(dir), 32'd0);
      chk_vec("rst_pos", 32'(pos), 32'd0);
      chk_vec("rst_err", 32'(err_cnt), 32'd0);

      snap_v = n_valid;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk_vec("init_b", 32'(b), 32'd0);
      chk_vec("init_pos", 32'(pos), 32'd0);
      chk_vec("init_err", 32'(err_cnt), 32'd0);
      tick();
      chk_vec("init_no_valid", 32'(n_valid - snap_v), 32'd0);

      // Full up walk with wrap 15 -> 0
      snap_v = n_valid;
      snap_e = n_serr;
      for (int k = 0; k < 16; k++) begin
         apply_step($sformatf("walk%0d", k), gray_up[k], 4'((k + 1) % 16), 1'b1, 1'b0);
         chk_vec($sformatf("walk%0d_pos", k), 32'(pos), 32'(k + 1));
      end
      chk_vec("walk_valid_cnt", 32'(n_valid - snap_v), 32'd16);
      chk_vec("walk_serr_cnt", 32'(n_serr - snap_e), 32'd0);

      // Clear with no step, then a down step 0 -> 15 wrapping pos below 0
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_vec("clear_pos", 32'(pos), 32'd0);
      apply_step("down", 4'b1000, 4'd15, 1'b0, 1'b0);
      chk_vec("down_pos", 32'(pos), 32'd255);

      // Back up 15 -> 0, then an illegal jump 0000 -> 0011
      apply_step("back", 4'b0000, 4'd0, 1'b1, 1'b0);
      chk_vec("back_pos", 32'(pos), 32'd0);
      apply_step("ill", 4'b0011, 4'd2, 1'b1, 1'b1);
      chk_vec("ill_pos", 32'(pos), 32'd0);
      chk_vec("ill_err", 32'(err_cnt), 32'd1);

      snap_e = n_serr;
      for (int k = 0; k < 20; k++) begin
         g = (k % 2 == 0) ? 4'b0000 : 4'b0011;
         for (int t = 0; t < 4; t++) tick();
      end
      chk_vec("sat_err", 32'(err_cnt), 32'd15);
      chk_vec("sat_serr_cnt", 32'(n_serr - snap_e), 32'd20);
      chk_vec("sat_pos", 32'(pos), 32'd0);
      chk_vec("sat_b", 32'(b), 32'd2);

      // Legal step 2 -> 3, then clear coinciding with step 3 -> 4
      apply_step("pre_clr", 4'b0010, 4'd3, 1'b1, 1'b0);
      chk_vec("pre_clr_pos", 32'(pos), 32'd1);
      chk_vec("pre_clr_err", 32'(err_cnt), 32'd15);
      g = 4'b0110;
      tick();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_vec("clr_valid", 32'(valid), 32'd1);
      chk_vec("clr_b", 32'(b), 32'd4);
      chk_vec("clr_dir", 32'(dir), 32'd1);
      chk_vec("clr_pos", 32'(pos), 32'd0);
      chk_vec("clr_err", 32'(err_cnt), 32'd0);
      tick();

      // Legal step 4 -> 5, then reset one edge after g moves to 0101
      apply_step("pre_rst", 4'b0111, 4'd5, 1'b1, 1'b0);
      chk_vec("pre_rst_pos", 32'(pos), 32'd1);
      g = 4'b0101;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_vec("mrst_b", 32'(b), 32'd0);
      chk_vec("mrst_valid", 32'(valid), 32'd0);
      chk_vec("mrst_pos", 32'(pos), 32'd0);
      chk_vec("mrst_dir", 32'(dir), 32'd0);
      snap_v = n_valid;
      tick();
      chk_vec("reinit1_b", 32'(b), 32'd0);
      tick();
      chk_vec("reinit2_b", 32'(b), 32'd0);
      tick();
      chk_vec("reinit3_b", 32'(b), 32'd6);
      chk_vec("reinit3_valid", 32'(valid), 32'd0);
      chk_vec("reinit3_pos", 32'(pos), 32'd0);
      tick();
      tick();
      chk_vec("reinit_b_hold", 32'(b), 32'd6);
      chk_vec("reinit_no_valid", 32'(n_valid - snap_v), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/grey_to_bin_tracker.md
GREY_TO_BIN_TRACKER -- requirements
Module: grey_to_bin_tracker

Interface
REQ-001 The parameter list SHALL be exactly: WIDTH, default 4, Gray/binary word width.
REQ-002 The module SHALL use a single clock and a synchronous, active-high reset.
REQ-003 The ports SHALL be, in order:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- g  input  WIDTH  Gray-coded word from an asynchronous source.
- clear  input  1  synchronous clear of pos and err_cnt.
- b  output  WIDTH  registered binary equivalent of the last accepted Gray word.
- valid  output  1  one-cycle pulse when b changes.
- dir  output  1  1 = last legal step was up, 0 = down.
- step_err  output  1  one-cycle pulse on an illegal (multi-bit) Gray transition.
- pos  output  8  wrap-around step accumulator.
- err_cnt  output  4  saturating count of illegal transitions.

Function
REQ-004 g SHALL pass through a 2-flop synchronizer (s1, s2) before any use.
REQ-005 Gray-to-binary conversion SHALL be b[WIDTH-1]=s2[WIDTH-1] and b[i]=b[i+1]^s2[i] for i<WIDTH-1.
REQ-006 The FSM SHALL have states INIT and TRACK; reset SHALL enter INIT.
REQ-007 INIT SHALL last exactly 2 cycles to fill the synchronizer, and SHALL then:
- load b from the converted s2;
- keep valid, step_err, pos and err_cnt unchanged;
- enter TRACK.
REQ-008 In TRACK, each cycle SHALL compare s2 against the previous s2 value (gprev).
- 0 differing bits: no action, valid=0.
- Exactly 1 differing bit (legal step): update b, assert valid for 1 cycle, set dir, then pos+1 if up or pos-1 if down.
- More than 1 differing bit (illegal step): update b, assert valid and step_err for 1 cycle, keep dir and pos, increment err_cnt.
REQ-009 Up SHALL mean new_b == old_b+1 mod 2^WIDTH, so max->0 (Gray 1000->0000 at WIDTH=4) is a legal up step and 0->max is a legal down step.
REQ-010 pos SHALL wrap modulo 256 in both directions; err_cnt SHALL saturate at 15.
REQ-011 Latency: a g change stable before edge k SHALL appear on b/valid after edge k+2.
REQ-012 If clear and a step occur in the same cycle:
- clear SHALL win for pos and err_cnt (both become 0);
- b, valid, dir and step_err SHALL still update normally.
REQ-013 clear in INIT SHALL zero pos and err_cnt and SHALL NOT affect the INIT timing.

Reset
REQ-014 On rst high at a clock edge, s1, s2, gprev, b, pos and err_cnt SHALL become 0; valid, step_err and dir SHALL become 0; the state SHALL become INIT.
REQ-015 Reset asserted mid-operation SHALL discard any in-flight synchronizer data; no valid pulse SHALL occur in the cycle after reset release.
REQ-016 rst SHALL take priority over clear and all other inputs.

Structure
REQ-017 A shared package grey_pkg SHALL hold:
- WIDTH default constant;
- state typedef (INIT, TRACK);
- a gray2bin conversion function reused by the existing bin/grey blocks' benches.
REQ-018 The synchronizer SHALL be a separate sub-module grey_sync2, parameterized by WIDTH, with clk/rst.
REQ-019 All outputs SHALL be registered; no combinational path from g to any output.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios:
- Reset then g=0000 held: after 2 INIT cycles b=0, pos=0, valid never pulses, err_cnt=0.
- Walk g through the full 16-entry up Gray sequence, one step per 4 cycles: 16 valid pulses, dir=1 each time, b goes 0..15 then 0, pos=16, step_err never asserted.
- From b=0 (g=0000), step g to 1000 (binary 15): legal down step, dir=0, pos=255 (wrap below 0).
- Jump g 0000->0011: step_err pulses once, b=2, pos unchanged, err_cnt=1; repeat 20 illegal jumps -> err_cnt saturates at 15.
- clear asserted in the same cycle as a legal up step: pos=0, err_cnt=0, valid=1, b updated.
- rst asserted 1 cycle after g changes, before b updates: b=0, no valid; after release, INIT reloads b from the current g with no valid or pos change.
